// File: rtl/top_pkg.sv
// -----------------------------------------------------------------------------
// top_pkg
// Shared definitions for the fixed-point rounding/saturation block.
//   - Default widths: Q8.8 signed input, 8-bit signed integer output.
//   - HALF_LSB: half of one output LSB in input units (0.5 in Q8.8).
//   - OUT_MAX / OUT_MIN: saturation limits of the 8-bit signed output.
//   - q8_8_t: the signed Q8.8 input word.
// -----------------------------------------------------------------------------
package top_pkg;

    localparam int IN_W_DEF   = 16;
    localparam int FRAC_W_DEF = 8;
    localparam int OUT_W_DEF  = 8;

    localparam logic [15:0] HALF_LSB = 16'h0080;
    localparam int          OUT_MAX  = 127;
    localparam int          OUT_MIN  = -128;

    typedef logic signed [15:0] q8_8_t;

endpackage

// File: rtl/top_round_sat.sv
// -----------------------------------------------------------------------------
// round_sat
// Purely combinational rounding of a signed fixed-point word to a signed
// integer, followed by saturation to OUT_W bits.
// Optional feature macro: ROUND_CONV_EN -- ties (fraction exactly one half)
// round to the nearest even integer instead of half-up.
// Ports:
//   fixed_point_in  in   IN_W     signed fixed-point input
//   temp_res        out  OUT_W+1  rounded value before saturation
//   result          out  OUT_W    saturated integer
//   overflow        out  1        result was clamped
// -----------------------------------------------------------------------------
module round_sat
    import top_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  fixed_point_in,
    output logic [OUT_W:0]   temp_res,
    output logic [OUT_W-1:0] result,
    output logic             overflow
);

    // Half of one integer step in input units; equals HALF_LSB for Q8.8.
    localparam logic signed [IN_W:0]  HALF    = $signed((IN_W+1)'(1) << (FRAC_W - 1));
    localparam logic signed [OUT_W:0] SAT_MAX = $signed((OUT_W+1)'((1 << (OUT_W - 1)) - 1));
    localparam logic signed [OUT_W:0] SAT_MIN = $signed((OUT_W+1)'(-(1 << (OUT_W - 1))));

    logic signed [IN_W:0]  sum_s;
    logic signed [OUT_W:0] raw_s;
    logic signed [OUT_W:0] temp_s;

    // One extra bit of headroom so adding the half LSB to the most positive
    // input cannot wrap; the shifted result always fits in OUT_W+1 bits.
    assign sum_s = $signed({fixed_point_in[IN_W-1], fixed_point_in}) + HALF;
    assign raw_s = (OUT_W+1)'(sum_s >>> FRAC_W);

`ifdef ROUND_CONV_EN
    logic tie_s;

    assign tie_s = (fixed_point_in[FRAC_W-1:0] == HALF[FRAC_W-1:0]);

    // On an exact tie half-up lands on k+1; pull odd results back to even k.
    always_comb begin
        temp_s = raw_s;
        if (tie_s && raw_s[0]) begin
            temp_s = raw_s - $signed((OUT_W+1)'(1));
        end else begin
            temp_s = raw_s;
        end
    end
`else
    // Plain round-half-up.
    always_comb begin
        temp_s = raw_s;
    end
`endif

    assign temp_res = temp_s;

    // Clamp to the signed OUT_W range and flag any clamping.
    always_comb begin
        result   = temp_s[OUT_W-1:0];
        overflow = 1'b0;
        if (temp_s > SAT_MAX) begin
            result   = SAT_MAX[OUT_W-1:0];
            overflow = 1'b1;
        end else if (temp_s < SAT_MIN) begin
            result   = SAT_MIN[OUT_W-1:0];
            overflow = 1'b1;
        end else begin
            result   = temp_s[OUT_W-1:0];
            overflow = 1'b0;
        end
    end

endmodule

// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top
// Registered fixed-point to integer converter with rounding, saturation and
// a saturating count of clamped results. One cycle of latency, no backpressure.
// Optional feature macro: ROUND_CONV_EN (round ties to even, see round_sat).
// Ports:
//   clk                  in   1      clock, rising edge
//   rst                  in   1      asynchronous active-high reset
//   in_valid             in   1      fixed_point_in is valid this cycle
//   fixed_point_in       in   IN_W   signed Q8.8 value
//   out_valid            out  1      outputs below are valid this cycle
//   rounded_integer_out  out  OUT_W  rounded, saturated integer
//   overflow             out  1      result was clamped
//   sat_count            out  16     clamped results since reset (saturating)
// -----------------------------------------------------------------------------
module top
    import top_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  fixed_point_in,
    output logic             out_valid,
    output logic [OUT_W-1:0] rounded_integer_out,
    output logic             overflow,
    output logic [15:0]      sat_count
);

    logic [OUT_W:0]   temp_res;
    logic [OUT_W-1:0] result_s;
    logic             overflow_s;

    round_sat #(
        .IN_W   (IN_W),
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
    ) u_round_sat (
        .fixed_point_in (fixed_point_in),
        .temp_res       (temp_res),
        .result         (result_s),
        .overflow       (overflow_s)
    );

    // Output pipe stage: data registers only load on a valid sample so they
    // hold their last value across gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid           <= 1'b0;
            rounded_integer_out <= '0;
            overflow            <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                rounded_integer_out <= result_s;
                overflow            <= overflow_s;
            end else begin
                rounded_integer_out <= rounded_integer_out;
                overflow            <= overflow;
            end
        end
    end

    // Count clamped samples, sticking at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= 16'h0000;
        end else if (in_valid && overflow_s && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'h0001;
        end else begin
            sat_count <= sat_count;
        end
    end

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top -- scoreboard bench for top. Each driven cycle pushes the expected
// outputs (from a real-arithmetic reference model) into a queue once the
// capturing edge has passed; a monitor pops and compares on falling edges.
// -----------------------------------------------------------------------------
module tb_top;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] fixed_point_in;
    logic        out_valid;
    logic [7:0]  rounded_integer_out;
    logic        overflow;
    logic [15:0] sat_count;

    typedef struct {
        bit          v;
        logic [7:0]  out;
        bit          ovf;
        logic [15:0] cnt;
    } rec_t;

    rec_t        sb_q[$];
    int          tests  = 0;
    int          fails  = 0;
    int          m_cnt  = 0;
    logic [7:0]  m_last = 8'h00;
    bit          m_lovf = 1'b0;

    top dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .fixed_point_in      (fixed_point_in),
        .out_valid           (out_valid),
        .rounded_integer_out (rounded_integer_out),
        .overflow            (overflow),
        .sat_count           (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: round the real value x = w/256 to nearest, ties per build,
    // then clamp to [-128,127].
    task automatic model(input logic [15:0] w, output logic [7:0] out, output bit ovf);
        real x, f, fr;
        int  r;
        x  = $itor($signed(w)) / 256.0;
        f  = $floor(x);
        fr = x - f;
        if (fr > 0.5) r = $rtoi(f) + 1;
        else if (fr < 0.5) r = $rtoi(f);
        else begin
`ifdef ROUND_CONV_EN
            r = ($rtoi(f) % 2 == 0) ? $rtoi(f) : $rtoi(f) + 1;
`else
            r = $rtoi(f) + 1;
`endif
        end
        if (r > 127) begin out = 8'h7F; ovf = 1'b1; end
        else if (r < -128) begin out = 8'h80; ovf = 1'b1; end
        else begin out = 8'(r); ovf = 1'b0; end
    endtask

    // Called at posedge+1: present inputs, let the next edge capture them,
    // then queue what the monitor should see at the following falling edge.
    task automatic send(input bit v, input logic [15:0] w);
        rec_t r;
        logic [7:0] o;
        bit ov;
        in_valid       = v;
        fixed_point_in = w;
        @(posedge clk);
        #1;
        if (v) begin
            model(w, o, ov);
            if (ov && m_cnt < 65535) m_cnt++;
            m_last = o;
            m_lovf = ov;
        end
        r.v = v; r.out = m_last; r.ovf = m_lovf; r.cnt = 16'(m_cnt);
        sb_q.push_back(r);
    endtask

    // Reset asserted between edges with a sample in flight.
    task automatic mid_reset(input logic [15:0] w);
        in_valid       = 1'b1;
        fixed_point_in = w;
        #2;
        rst = 1'b1;
        sb_q.delete();
        m_cnt = 0; m_last = 8'h00; m_lovf = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out", int'(rounded_integer_out), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_sat_count", int'(sat_count), 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare every expected cycle record against the DUT.
    always @(negedge clk) begin
        rec_t r;
        if (!rst && sb_q.size() > 0) begin
            r = sb_q.pop_front();
            check("out_valid", int'(out_valid), int'(r.v));
            check(r.v ? "out" : "out_hold", int'(rounded_integer_out), int'(r.out));
            check(r.v ? "overflow" : "overflow_hold", int'(overflow), int'(r.ovf));
            check("sat_count", int'(sat_count), int'(r.cnt));
        end
    end

    initial begin
        logic [15:0] w;
        rst = 1'b1; in_valid = 1'b0; fixed_point_in = 16'h0000;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out", int'(rounded_integer_out), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_sat_count", int'(sat_count), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Sweep 0x0000 upward in steps of 0x0010.
        for (int i = 0; i < 149; i++) send(1'b1, 16'(i * 16));

        // Ties.
        send(1'b1, 16'h0180);
        send(1'b1, 16'h0280);
        send(1'b1, 16'hFF80);
        send(1'b1, 16'hFE80);
        send(1'b1, 16'h8080);

        // Saturation from a clean counter.
        mid_reset(16'h7FFF);
        send(1'b1, 16'h7F80);
        send(1'b1, 16'h7FFF);
        send(1'b1, 16'h8000);
        send(1'b0, 16'h0000);

        // Handshake 1,0,1 with held outputs in the gap.
        send(1'b1, 16'h0370);
        send(1'b0, 16'h7FFF);
        send(1'b1, 16'hFC40);
        send(1'b0, 16'h0000);

        // Random traffic, biased towards extremes and exact ties.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       w = {8'($urandom), 8'h80};
                1:       w = 16'($urandom_range(0, 1) ? 16'h7F00 + $urandom_range(0, 255)
                                                      : 16'h8000 + $urandom_range(0, 255));
                default: w = 16'($urandom);
            endcase
            send($urandom_range(0, 3) != 0, w);
            if (i == 200) begin
                mid_reset(16'($urandom));
                for (int k = 0; k < 3; k++) send(1'b0, 16'($urandom));
            end
        end

        send(1'b0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter IN_W, default 16: input word width, signed Q(IN_W-FRAC_W).FRAC_W.
REQ-002 Parameter FRAC_W, default 8: fractional bits of the input.
REQ-003 Parameter OUT_W, default 8: signed integer output width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  qualifies fixed_point_in for one cycle.
REQ-007 fixed_point_in  input  IN_W  signed Q8.8 value.
REQ-008 out_valid  output  1  rounded_integer_out and overflow are valid this cycle.
REQ-009 rounded_integer_out  output  OUT_W  signed, rounded, saturated integer.
REQ-010 overflow  output  1  result was clamped, qualified by out_valid.
REQ-011 sat_count  output  16  number of clamped results since reset.

Function
REQ-012 Rounding: sign-extend input to IN_W+1 bits, add the half LSB 0x0080, then arithmetic-shift right by FRAC_W; the result is temp_res, signed OUT_W+1 bits (9 bits, range -128..+128).
- Default rounding is round-half-up (toward +infinity on ties).
REQ-013 Saturation: temp_res > 127 gives output 127 (0x7F) with overflow=1; temp_res < -128 gives -128 (0x80) with overflow=1; otherwise output is temp_res[OUT_W-1:0] with overflow=0.
REQ-014 temp_res and overflow exist as named internal signals, visible hierarchically for debug.
REQ-015 Latency is exactly 1 cycle: the sample accepted with in_valid=1 at edge N appears with out_valid=1 after edge N.
REQ-016 With in_valid=0, out_valid=0 on the next cycle; rounded_integer_out and overflow hold their last values.
REQ-017 Back-to-back in_valid is accepted every cycle; there is no backpressure.
REQ-018 sat_count increments by 1 per accepted sample with overflow=1 and saturates at 0xFFFF, with no wrap-around.

Reset
REQ-019 While rst=1, out_valid=0, rounded_integer_out=0, overflow=0 and sat_count=0, asynchronously.
REQ-020 A sample in flight when rst asserts is discarded; the first valid output after release comes from the first post-release in_valid.

Configuration
REQ-021 With macro ROUND_CONV_EN defined, ties (fraction exactly 0x80) round to the nearest even integer; every non-tie input rounds exactly as in the default build.
REQ-022 Without ROUND_CONV_EN, ties round half-up as in REQ-012.
REQ-023 Saturation applies identically in both builds.

Structure
REQ-024 A shared package top_pkg holds IN_W/FRAC_W/OUT_W defaults, the constants HALF_LSB (0x0080), OUT_MAX (127) and OUT_MIN (-128), and a typedef for the Q8.8 word.
REQ-025 One combinational sub-module, round_sat, performs rounding and saturation; top adds only the registers, the valid pipe and the counter.

Verification
REQ-026 Sweep: start at 0x0000 and add 0x0010 each cycle for 149 samples.
- Each output equals the rounded real value: 0x0070 (0.4375) -> 0; 0x0080 -> 1; 0x0170 -> 1.
- overflow=0 throughout.
REQ-027 Ties: 0x0180 (1.5) -> 2 in both builds.
- 0x0280 (2.5) -> 3 by default, 2 with ROUND_CONV_EN.
- 0xFF80 (-0.5) -> 0 in both builds.
REQ-028 Saturation:
- 0x7F80 -> temp_res 128, output 0x7F, overflow=1.
- 0x7FFF -> 0x7F, overflow=1.
- 0x8000 -> 0x80, overflow=0.
- sat_count=2 after these three samples.
REQ-029 Handshake: in_valid pattern 1,0,1 -> out_valid pattern 0,1,0,1 (1-cycle delay); output holds during the gap.
REQ-030 Reset mid-stream: assert rst between clock edges.
- Outputs and sat_count go to 0 immediately.
- No stale out_valid appears after release.
